// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-ROM request port (req/ack handshake)
interface pc_gen_if;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  modport master (output rom_req_o, rom_addr_o, input rom_ack_i);
  modport slave (input rom_req_o, rom_addr_o, output rom_ack_i);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with ROM req/ack fetch, jump redirect and hold buffer
module pc_gen #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  pc_gen_if.master    rom,
  output logic [31:0] pc_addr_o,
  output logic        pc_valid_o,
  output logic        jump_misalign_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, buf_addr, buf_addr_nx, pc_addr_nx, target;
  logic buf_valid, buf_valid_nx, pc_valid_nx, accept, drain;
  // Request generation, accept/drain detection and next-state selection; jump outranks hold and ack
  always_comb begin
    target = {jump_addr_i[31:2], 2'b00};
    rom.rom_addr_o = pc;
    rom.rom_req_o = !rst && (state != IDLE || (!hold_flag_i && !buf_valid && !jump_en_i));
    accept = rom.rom_req_o && rom.rom_ack_i && state != DROP;
    drain = buf_valid && !hold_flag_i && !jump_en_i;
    state_nx = state;
    pc_nx = pc;
    buf_addr_nx = buf_addr;
    buf_valid_nx = buf_valid;
    pc_addr_nx = pc_addr_o;
    pc_valid_nx = pc_valid_o;
    if (jump_en_i) begin
      pc_nx = target;
      buf_valid_nx = 1'b0;
      pc_valid_nx = 1'b0;
      state_nx = (state != IDLE && !rom.rom_ack_i) ? DROP : IDLE;
    end else begin
      if (accept) begin
        pc_nx = pc + 32'd4;
        state_nx = IDLE;
        buf_addr_nx = hold_flag_i ? pc : buf_addr;
        buf_valid_nx = hold_flag_i ? 1'b1 : buf_valid;
        pc_addr_nx = hold_flag_i ? pc_addr_o : pc;
        pc_valid_nx = hold_flag_i ? pc_valid_o : 1'b1;
      end else if (state == IDLE && rom.rom_req_o) begin
        state_nx = WAIT;
      end else if (state == DROP && rom.rom_ack_i) begin
        state_nx = IDLE;
      end
      if (drain) begin
        pc_addr_nx = buf_addr;
        pc_valid_nx = 1'b1;
        buf_valid_nx = 1'b0;
      end else if (!hold_flag_i && !accept) begin
        pc_valid_nx = 1'b0;
      end
    end
  end
  // State, PC, hold buffer and fetch-stage output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_ADDR;
      buf_addr <= 32'h0;
      buf_valid <= 1'b0;
      pc_addr_o <= 32'h0;
      pc_valid_o <= 1'b0;
      jump_misalign_o <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      buf_addr <= buf_addr_nx;
      buf_valid <= buf_valid_nx;
      pc_addr_o <= pc_addr_nx;
      pc_valid_o <= pc_valid_nx;
      jump_misalign_o <= jump_en_i && |jump_addr_i[1:0];
    end
  end
endmodule
